// File: rtl/svfloat_pkg.sv
// Float format descriptor, rounding modes, class codes and exception flag
// indices shared by the float-to-integer and mul/div datapaths.
package svfloat;

    typedef struct packed {
        logic [7:0]  exp_w;
        logic [7:0]  man_w;
        logic [15:0] bias;
    } fmt_t;

    localparam fmt_t float32 = '{exp_w: 8'd8, man_w: 8'd23, bias: 16'd127};

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_t;

    typedef enum logic [2:0] {
        FC_ZERO = 3'd0,
        FC_SUB  = 3'd1,
        FC_NORM = 3'd2,
        FC_INF  = 3'd3,
        FC_NAN  = 3'd4
    } fclass_e;

    localparam int FLAG_W  = 5;
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Reserved encodings 5..7 fall back to round-to-nearest-even.
    function automatic rm_t decode_rm(input logic [2:0] raw);
        rm_t rm;
        case (raw)
            3'd1:    rm = RM_RTZ;
            3'd2:    rm = RM_RDN;
            3'd3:    rm = RM_RUP;
            3'd4:    rm = RM_RMM;
            default: rm = RM_RNE;
        endcase
        return rm;
    endfunction

endpackage

// File: rtl/fclassify.sv
// Unpack/classify a packed float: sign, biased exponent, mantissa with hidden bit, class.
// Latency: combinational.
// Backpressure: none, pure function of the input word.
import svfloat::*;

module fclassify #(
    parameter fmt_t FMT = float32,
    localparam int EW = int'(FMT.exp_w),
    localparam int MW = int'(FMT.man_w)
) (
    input  logic [EW+MW:0] f,
    output logic           sign,
    output logic [EW-1:0]  bexp,
    output logic [MW:0]    mant,
    output logic [2:0]     cls
);

    logic [MW-1:0] frac;
    logic          exp_ones;
    logic          exp_zero;

    assign sign     = f[EW+MW];
    assign bexp     = f[EW+MW-1:MW];
    assign frac     = f[MW-1:0];
    assign exp_ones = &bexp;
    assign exp_zero = ~|bexp;
    assign mant     = {~exp_zero, frac};

    always_comb begin
        cls = FC_NORM;
        if (exp_ones) begin
            cls = (|frac) ? FC_NAN : FC_INF;
        end else if (exp_zero) begin
            cls = (|frac) ? FC_SUB : FC_ZERO;
        end
    end

endmodule

// File: rtl/ftoi_pipe.sv
// Float to signed/unsigned integer with RISC-V fcvt rounding and NV/NX flags.
// Latency: 3 cycles (unpack, align, round/saturate), one word per cycle.
// Backpressure: global stall while out_valid && !out_ready; in_ready = !stall.
import svfloat::*;

module ftoi_pipe #(
    parameter fmt_t FMT   = float32,
    parameter int   INT_W = 32,
    localparam int  EW    = int'(FMT.exp_w),
    localparam int  MW    = int'(FMT.man_w),
    localparam int  FW    = EW + MW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FW-1:0]     in_data,
    input  logic              in_signed,
    input  logic [2:0]        in_rm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INT_W-1:0]  out_data,
    output logic [4:0]        out_flags
);

    localparam int BIAS = int'(FMT.bias);
    localparam logic signed [EW+1:0] E_BIAS = (EW+2)'(BIAS);
    localparam logic signed [EW+1:0] E_INTW = (EW+2)'(INT_W);
    localparam logic [INT_W-1:0] SMAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] SMIN = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic [INT_W-1:0] UMAX = {INT_W{1'b1}};

    logic stall;
    logic en;

    assign stall    = out_valid && !out_ready;
    assign en       = !stall;
    assign in_ready = en;

    // ---------------- stage 1: unpack ----------------
    logic          c_sign;
    logic [EW-1:0] c_exp;
    logic [MW:0]   c_mant;
    logic [2:0]    c_cls;

    fclassify #(.FMT(FMT)) u_fclassify (
        .f    (in_data),
        .sign (c_sign),
        .bexp (c_exp),
        .mant (c_mant),
        .cls  (c_cls)
    );

    logic          s1_vld;
    logic          s1_sign;
    logic [EW-1:0] s1_exp;
    logic [MW:0]   s1_mant;
    logic [2:0]    s1_cls;
    logic          s1_signed;
    rm_t           s1_rm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_sign   <= 1'b0;
            s1_exp    <= '0;
            s1_mant   <= '0;
            s1_cls    <= FC_ZERO;
            s1_signed <= 1'b0;
            s1_rm     <= RM_RNE;
        end else if (en) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_sign   <= c_sign;
                s1_exp    <= c_exp;
                s1_mant   <= c_mant;
                s1_cls    <= c_cls;
                s1_signed <= in_signed;
                s1_rm     <= decode_rm(in_rm);
            end
        end
    end

    // ---------------- stage 2: align ----------------
    logic signed [EW+1:0]  e;
    logic [INT_W+MW-1:0]   ext;
    logic [INT_W+MW-1:0]   sh;
    logic [INT_W-1:0]      n_mag;
    logic                  n_g;
    logic                  n_st;
    logic                  n_ovf;

    assign e   = $signed({2'b00, s1_exp}) - E_BIAS;
    assign ext = {{(INT_W-1){1'b0}}, s1_mant};
    // Only consumed when 0 <= e < INT_W, so the shift never drops integer bits.
    assign sh  = ext << e;

    always_comb begin
        n_mag = '0;
        n_g   = 1'b0;
        n_st  = 1'b0;
        n_ovf = 1'b0;
        case (fclass_e'(s1_cls))
            FC_SUB: n_st = 1'b1;
            FC_NORM: begin
                if (e[EW+1]) begin
                    // Magnitude below 1: only e == -1 puts the hidden bit in the guard position.
                    if (&e) begin
                        n_g  = s1_mant[MW];
                        n_st = |s1_mant[MW-1:0];
                    end else begin
                        n_st = 1'b1;
                    end
                end else if (e >= E_INTW) begin
                    n_ovf = 1'b1;
                end else begin
                    n_mag = sh[INT_W+MW-1:MW];
                    n_g   = sh[MW-1];
                    n_st  = |sh[MW-2:0];
                end
            end
            default: ;
        endcase
    end

    logic             s2_vld;
    logic             s2_sign;
    logic [INT_W-1:0] s2_mag;
    logic             s2_g;
    logic             s2_st;
    logic             s2_ovf;
    logic             s2_inf;
    logic             s2_nan;
    logic             s2_signed;
    rm_t              s2_rm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld    <= 1'b0;
            s2_sign   <= 1'b0;
            s2_mag    <= '0;
            s2_g      <= 1'b0;
            s2_st     <= 1'b0;
            s2_ovf    <= 1'b0;
            s2_inf    <= 1'b0;
            s2_nan    <= 1'b0;
            s2_signed <= 1'b0;
            s2_rm     <= RM_RNE;
        end else if (en) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_sign   <= s1_sign;
                s2_mag    <= n_mag;
                s2_g      <= n_g;
                s2_st     <= n_st;
                s2_ovf    <= n_ovf;
                s2_inf    <= (s1_cls == FC_INF);
                s2_nan    <= (s1_cls == FC_NAN);
                s2_signed <= s1_signed;
                s2_rm     <= s1_rm;
            end
        end
    end

    // ---------------- stage 3: round and saturate ----------------
    logic             inexact;
    logic             inc;
    logic [INT_W:0]   rmag;
    logic [INT_W-1:0] pos_sat;
    logic [INT_W-1:0] neg_sat;
    logic [INT_W-1:0] r_data;
    logic             r_nv;
    logic             r_nx;

    assign inexact = s2_g | s2_st;
    assign pos_sat = s2_signed ? SMAX : UMAX;
    assign neg_sat = s2_signed ? SMIN : '0;
    assign rmag    = {1'b0, s2_mag} + {{INT_W{1'b0}}, inc};

    always_comb begin
        case (s2_rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = s2_sign & inexact;
            RM_RUP:  inc = ~s2_sign & inexact;
            RM_RMM:  inc = s2_g;
            default: inc = s2_g & (s2_st | s2_mag[0]);
        endcase
    end

    always_comb begin
        r_data = '0;
        r_nv   = 1'b0;
        r_nx   = 1'b0;
        if (s2_nan) begin
            r_data = pos_sat;
            r_nv   = 1'b1;
        end else if (s2_inf || s2_ovf) begin
            r_data = s2_sign ? neg_sat : pos_sat;
            r_nv   = 1'b1;
        end else if (s2_signed) begin
            if (!s2_sign && rmag > {1'b0, SMAX}) begin
                r_data = SMAX;
                r_nv   = 1'b1;
            end else if (s2_sign && rmag > {1'b0, SMIN}) begin
                r_data = SMIN;
                r_nv   = 1'b1;
            end else begin
                r_data = s2_sign ? (~rmag[INT_W-1:0] + 1'b1) : rmag[INT_W-1:0];
                r_nx   = inexact;
            end
        end else if (!s2_sign) begin
            if (rmag[INT_W]) begin
                r_data = UMAX;
                r_nv   = 1'b1;
            end else begin
                r_data = rmag[INT_W-1:0];
                r_nx   = inexact;
            end
        end else if (|rmag) begin
            r_nv = 1'b1;
        end else begin
            r_nx = inexact;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_flags <= '0;
        end else if (en) begin
            out_valid <= s2_vld;
            if (s2_vld) begin
                out_data           <= r_data;
                out_flags          <= '0;
                out_flags[FLAG_NV] <= r_nv;
                out_flags[FLAG_NX] <= r_nx;
            end
        end
    end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Self-checking bench for ftoi_pipe: directed conversion table, latency,
// throughput, backpressure and mid-stream reset, with a result scoreboard.
module tb_ftoi_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_flags;

    ftoi_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .in_rm     (in_rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] f;
        logic        sg;
        logic [2:0]  rm;
        logic [31:0] r;
        logic [4:0]  fl;
    } tv_t;

    tv_t         tv[$];
    logic [36:0] sb[$];
    logic [36:0] cur_exp;
    int          vectors;
    int          miscompares;
    int          pops;

    task automatic add_tv(input logic [31:0] f, input logic sg, input logic [2:0] rm,
                          input logic [31:0] r, input logic [4:0] fl);
        tv.push_back('{f: f, sg: sg, rm: rm, r: r, fl: fl});
    endtask

    task automatic drive(input int i);
        in_data   = tv[i].f;
        in_signed = tv[i].sg;
        in_rm     = tv[i].rm;
        cur_exp   = {tv[i].r, tv[i].fl};
        in_valid  = 1'b1;
    endtask

    // Pushes on accept, pops and compares on every consumed result.
    task automatic monitor();
        logic [36:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    vectors++;
                    pops++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL sb_unexpected: got data=%h flags=%h, required no output", out_data, out_flags);
                    end else begin
                        e = sb.pop_front();
                        if ({out_data, out_flags} !== e) begin
                            miscompares++;
                            $display("FAIL sb_result: got data=%h flags=%h, required data=%h flags=%h",
                                     out_data, out_flags, e[36:5], e[4:0]);
                        end
                    end
                end
                if (in_valid && in_ready) sb.push_back(cur_exp);
            end
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 100) begin
            @(negedge clk);
            #3;
            t++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d results still pending, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_signed = 1'b0;
        in_rm     = 3'd0;
        out_ready = 1'b1;
        cur_exp   = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors += 4;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        if (out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data: got %h required 0", out_data); end
        if (out_flags !== 5'h0) begin miscompares++; $display("FAIL reset_out_flags: got %h required 0", out_flags); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        int lat;
        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            drive(i);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            vectors++;
            if (lat !== 3) begin
                miscompares++;
                $display("FAIL latency[%0d]: got %0d cycles required 3", i, lat);
            end
            wait_drain();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ov;
        ov = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c < 8) drive(c);
            else in_valid = 1'b0;
            #3;
            ov[c] = out_valid;
        end
        vectors++;
        if (ov !== 16'h07F8) begin
            miscompares++;
            $display("FAIL b2b_valid_pattern: got %h required 07f8", ov);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int p0;
        p0 = pops;
        out_ready = 1'b0;
        fork
            begin
                int tries;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    drive(k + 8);
                    tries = 0;
                    #3;
                    while (!in_ready && tries < 50) begin
                        @(negedge clk);
                        #3;
                        tries++;
                    end
                    if (tries >= 50) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL bp_accept_timeout: word %0d never accepted", k);
                    end
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                int t;
                logic [31:0] d0;
                logic [4:0]  f0;
                t = 0;
                @(negedge clk);
                #3;
                while (!out_valid && t < 20) begin
                    @(negedge clk);
                    #3;
                    t++;
                end
                d0 = out_data;
                f0 = out_flags;
                for (int s = 0; s < 5; s++) begin
                    if (s > 0) begin
                        @(negedge clk);
                        #3;
                    end
                    vectors += 2;
                    if (in_ready !== 1'b0) begin
                        miscompares++;
                        $display("FAIL bp_in_ready[%0d]: got %b required 0", s, in_ready);
                    end
                    if (out_valid !== 1'b1 || out_data !== d0 || out_flags !== f0) begin
                        miscompares++;
                        $display("FAIL bp_stable[%0d]: got v=%b data=%h flags=%h required v=1 data=%h flags=%h",
                                 s, out_valid, out_data, out_flags, d0, f0);
                    end
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_drain();
        vectors++;
        if (pops - p0 !== 4) begin
            miscompares++;
            $display("FAIL bp_count: got %0d results required 4", pops - p0);
        end
    endtask

    task automatic test_reset_midstream();
        int stale;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive(c);
            #3;
        end
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre_reset_valid: got %b required 1", out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        vectors += 2;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_valid: got %b required 0", out_valid); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset_in_ready: got %b required 1", in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #3;
            if (out_valid) stale++;
        end
        vectors++;
        if (stale !== 0) begin
            miscompares++;
            $display("FAIL mid_stale_output: got %0d valid cycles required 0", stale);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pops        = 0;
        add_tv(32'h3FC00000, 1'b1, 3'd0, 32'h00000002, 5'h01);
        add_tv(32'h40200000, 1'b1, 3'd0, 32'h00000002, 5'h01);
        add_tv(32'h40200000, 1'b1, 3'd4, 32'h00000003, 5'h01);
        add_tv(32'hC0200000, 1'b1, 3'd2, 32'hFFFFFFFD, 5'h01);
        add_tv(32'hCF000000, 1'b1, 3'd0, 32'h80000000, 5'h00);
        add_tv(32'h4F000000, 1'b1, 3'd0, 32'h7FFFFFFF, 5'h10);
        add_tv(32'h4F000000, 1'b0, 3'd0, 32'h80000000, 5'h00);
        add_tv(32'hBF800000, 1'b0, 3'd0, 32'h00000000, 5'h10);
        add_tv(32'hBE800000, 1'b0, 3'd1, 32'h00000000, 5'h01);
        add_tv(32'h7FC00000, 1'b1, 3'd0, 32'h7FFFFFFF, 5'h10);
        add_tv(32'hFF800000, 1'b1, 3'd0, 32'h80000000, 5'h10);
        add_tv(32'h00000000, 1'b1, 3'd0, 32'h00000000, 5'h00);
        add_tv(32'h00000001, 1'b1, 3'd3, 32'h00000001, 5'h01);
        add_tv(32'h80000001, 1'b1, 3'd2, 32'hFFFFFFFF, 5'h01);
        add_tv(32'h3F800000, 1'b1, 3'd1, 32'h00000001, 5'h00);
        add_tv(32'hC0200000, 1'b1, 3'd1, 32'hFFFFFFFE, 5'h01);
        add_tv(32'h7F800000, 1'b0, 3'd0, 32'hFFFFFFFF, 5'h10);
        add_tv(32'h42F60000, 1'b0, 3'd0, 32'h0000007B, 5'h00);
        add_tv(32'hBFC00000, 1'b1, 3'd3, 32'hFFFFFFFF, 5'h01);
        add_tv(32'h3FC00000, 1'b1, 3'd7, 32'h00000002, 5'h01);
        add_tv(32'h4F800000, 1'b0, 3'd0, 32'hFFFFFFFF, 5'h10);
        add_tv(32'h3F000000, 1'b1, 3'd0, 32'h00000000, 5'h01);
        add_tv(32'h3F000000, 1'b1, 3'd4, 32'h00000001, 5'h01);
        add_tv(32'h7FC00000, 1'b0, 3'd0, 32'hFFFFFFFF, 5'h10);
        add_tv(32'hFF800000, 1'b0, 3'd0, 32'h00000000, 5'h10);
        fork
            monitor();
        join_none
        fork
            begin
                #500000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
